// File: rtl/if_stage_if.sv
// Fetch-stage bundle: instruction ROM port, ID handshake and redirect inputs.
interface if_stage_if;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_ready;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        flush;
  logic [31:0] new_pc;

  modport master (
    output rom_ce, rom_addr, id_valid, id_pc, id_inst,
    input  rom_inst, id_ready, branch_flag, branch_target, flush, new_pc
  );

  modport slave (
    input  rom_ce, rom_addr, id_valid, id_pc, id_inst,
    output rom_inst, id_ready, branch_flag, branch_target, flush, new_pc
  );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch: owns the PC, fetches from ROM into a 2-entry FIFO and
// presents the head to ID; handles delay-slot branches and flushes.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic      clk,
  input  logic      rst,
  if_stage_if.master bus
);

  logic [31:0] pc_reg, pc_next;
  logic        ce_reg;
  logic [1:0]  count_reg, count_next;
  logic        head_reg, head_next;
  logic        tail;
  logic        fetch, pop, take_branch;
  logic [1:0]  wr_en;
  logic [31:0] entry_pc   [2];
  logic [31:0] entry_inst [2];

  // With at most two entries the free slot is head when empty, the other one otherwise.
  assign tail = head_reg ^ count_reg[0];

  always_comb begin
    fetch       = ce_reg && (count_reg != 2'd2) && !bus.flush;
    pop         = (count_reg != 2'd0) && bus.id_ready && !bus.flush;
    take_branch = pop && bus.branch_flag;
    pc_next     = pc_reg;
    count_next  = count_reg;
    head_next   = head_reg;
    if (bus.flush) begin
      pc_next    = bus.new_pc;
      count_next = 2'd0;
      head_next  = 1'b0;
    end else begin
      // The delay slot is already queued or being fetched now, so only the PC moves.
      if (take_branch)
        pc_next = bus.branch_target;
      else if (fetch)
        pc_next = pc_reg + 32'd4;
      count_next = count_reg + {1'b0, fetch} - {1'b0, pop};
      head_next  = head_reg ^ pop;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_reg    <= RESET_PC;
      ce_reg    <= 1'b0;
      count_reg <= 2'd0;
      head_reg  <= 1'b0;
    end else begin
      pc_reg    <= pc_next;
      ce_reg    <= 1'b1;
      count_reg <= count_next;
      head_reg  <= head_next;
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_wr_en
      assign wr_en[gi] = fetch && (tail == 1'(gi));
    end
  endgenerate

  // Payload needs no reset: the outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (wr_en[i]) begin
        entry_pc[i]   <= pc_reg;
        entry_inst[i] <= bus.rom_inst;
      end
    end
  end

  assign bus.rom_ce   = ce_reg;
  assign bus.rom_addr = pc_reg;
  assign bus.id_valid = (count_reg != 2'd0);
  assign bus.id_pc    = bus.id_valid ? entry_pc[head_reg]   : 32'h0;
  assign bus.id_inst  = bus.id_valid ? entry_inst[head_reg] : 32'h0;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: queue reference model, program-order pop tracker,
// directed scenarios with literal expectations, then randomized traffic.
module tb_if_stage;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  bit   verbose  = 1'b1;

  if_stage_if bus ();

  if_stage #(.RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // ROM word k holds value k.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {2'b00, a[31:2]};
  endfunction

  assign bus.rom_inst = rom_word(bus.rom_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  // Reference model: a queue of fetched PCs, a PC and the enable flag.
  logic [31:0] m_q[$];
  logic [31:0] m_pc;
  logic        m_ce;
  bit          m_fetch, m_pop;

  // Program-order tracker: which PC must ID receive next.
  logic [31:0] arch_next;
  logic [31:0] arch_target;
  bit          arch_pending;

  always @(negedge clk) begin
    if (!rst) begin
      m_q.delete();
      m_pc         = RESET_PC;
      m_ce         = 1'b0;
      arch_next    = RESET_PC;
      arch_pending = 1'b0;
    end
    chk("rom_ce",   32'(bus.rom_ce), 32'(m_ce));
    chk("rom_addr", bus.rom_addr, m_pc);
    chk("id_valid", 32'(bus.id_valid), 32'(m_q.size() != 0));
    chk("id_pc",    bus.id_pc,   (m_q.size() != 0) ? m_q[0] : 32'h0);
    chk("id_inst",  bus.id_inst, (m_q.size() != 0) ? rom_word(m_q[0]) : 32'h0);
    if (rst) begin
      if (bus.flush) begin
        arch_next    = bus.new_pc;
        arch_pending = 1'b0;
      end else if (bus.id_valid && bus.id_ready) begin
        chk("pop_order", bus.id_pc, arch_next);
        if (verbose)
          $display("pop pc=%h inst=%h branch=%0b", bus.id_pc, bus.id_inst, bus.branch_flag);
        if (arch_pending) begin
          arch_next    = arch_target;
          arch_pending = 1'b0;
        end else begin
          arch_next = arch_next + 32'd4;
        end
        if (bus.branch_flag) begin
          arch_pending = 1'b1;
          arch_target  = bus.branch_target;
        end
      end
      // Advance the model to the state after the coming rising edge.
      m_fetch = m_ce && (m_q.size() < 2) && !bus.flush;
      m_pop   = (m_q.size() != 0) && bus.id_ready && !bus.flush;
      if (bus.flush) begin
        m_q.delete();
        m_pc = bus.new_pc;
      end else begin
        if (m_pop) void'(m_q.pop_front());
        if (m_fetch) m_q.push_back(m_pc);
        if (m_pop && bus.branch_flag) m_pc = bus.branch_target;
        else if (m_fetch) m_pc = m_pc + 32'd4;
      end
      m_ce = 1'b1;
    end
  end

  initial begin
    rst               = 1'b1;
    bus.id_ready      = 1'b1;
    bus.branch_flag   = 1'b0;
    bus.branch_target = 32'h0;
    bus.flush         = 1'b0;
    bus.new_pc        = 32'h0;
    #2 rst = 1'b0;
    #1;
    chk("rst_rom_ce",   32'(bus.rom_ce), 32'h0);
    chk("rst_rom_addr", bus.rom_addr, RESET_PC);
    chk("rst_id_valid", 32'(bus.id_valid), 32'h0);
    chk("rst_id_pc",    bus.id_pc, 32'h0);
    chk("rst_id_inst",  bus.id_inst, 32'h0);
    tick; tick;
    rst = 1'b1;

    // Start-up with id_ready held high.
    tick;
    chk("su1_rom_ce",   32'(bus.rom_ce), 32'h1);
    chk("su1_id_valid", 32'(bus.id_valid), 32'h0);
    tick;
    chk("su2_id_valid", 32'(bus.id_valid), 32'h1);
    chk("su2_id_pc",    bus.id_pc, 32'h0);
    chk("su2_rom_addr", bus.rom_addr, 32'h4);
    tick;
    chk("su3_id_pc",   bus.id_pc, 32'h4);
    chk("su3_id_inst", bus.id_inst, 32'h1);
    tick;
    chk("su4_id_pc",   bus.id_pc, 32'h8);
    chk("su4_id_inst", bus.id_inst, 32'h2);

    // Mid-stream reset, then back-pressure from start-up.
    rst = 1'b0;
    #1;
    chk("mid_rst_rom_ce",   32'(bus.rom_ce), 32'h0);
    chk("mid_rst_rom_addr", bus.rom_addr, RESET_PC);
    chk("mid_rst_id_valid", 32'(bus.id_valid), 32'h0);
    chk("mid_rst_id_pc",    bus.id_pc, 32'h0);
    bus.id_ready = 1'b0;
    tick;
    rst = 1'b1;
    for (int i = 0; i < 7; i++) tick;
    chk("bp_rom_addr", bus.rom_addr, 32'h8);
    chk("bp_id_pc",    bus.id_pc, 32'h0);
    chk("bp_id_valid", 32'(bus.id_valid), 32'h1);
    bus.id_ready = 1'b1;
    tick;
    chk("bp_rel1_id_pc", bus.id_pc, 32'h4);
    tick;
    chk("bp_rel2_id_pc", bus.id_pc, 32'h8);

    // Branch while one entry is queued.
    bus.flush = 1'b1; bus.new_pc = 32'h10;
    tick;
    chk("fl_id_valid", 32'(bus.id_valid), 32'h0);
    chk("fl_rom_addr", bus.rom_addr, 32'h10);
    bus.flush = 1'b0;
    tick;
    chk("b1_head", bus.id_pc, 32'h10);
    bus.branch_flag = 1'b1; bus.branch_target = 32'h100;
    tick;
    bus.branch_flag = 1'b0;
    chk("b1_slot",     bus.id_pc, 32'h14);
    chk("b1_rom_addr", bus.rom_addr, 32'h100);
    tick;
    chk("b1_target", bus.id_pc, 32'h100);

    // Branch while two entries are queued.
    bus.flush = 1'b1; bus.new_pc = 32'h10; bus.id_ready = 1'b0;
    tick;
    bus.flush = 1'b0;
    tick; tick;
    bus.id_ready = 1'b1; bus.branch_flag = 1'b1; bus.branch_target = 32'h200;
    tick;
    bus.branch_flag = 1'b0;
    chk("b2_slot",     bus.id_pc, 32'h14);
    chk("b2_rom_addr", bus.rom_addr, 32'h200);
    tick;
    chk("b2_target", bus.id_pc, 32'h200);

    // Flush wins over a branch with a full FIFO.
    bus.id_ready = 1'b0;
    tick;
    bus.id_ready = 1'b1; bus.branch_flag = 1'b1; bus.branch_target = 32'h500;
    bus.flush = 1'b1; bus.new_pc = 32'h380;
    tick;
    bus.branch_flag = 1'b0; bus.flush = 1'b0;
    chk("fb_id_valid", 32'(bus.id_valid), 32'h0);
    chk("fb_rom_addr", bus.rom_addr, 32'h380);
    tick;
    chk("fb_id_pc1", bus.id_pc, 32'h380);
    tick;
    chk("fb_id_pc2", bus.id_pc, 32'h384);

    // PC wrap-around.
    bus.flush = 1'b1; bus.new_pc = 32'hFFFF_FFFC;
    tick;
    bus.flush = 1'b0;
    tick;
    chk("wrap_pc_hi",   bus.id_pc, 32'hFFFF_FFFC);
    chk("wrap_inst_hi", bus.id_inst, 32'h3FFF_FFFF);
    tick;
    chk("wrap_pc_lo",   bus.id_pc, 32'h0);
    chk("wrap_inst_lo", bus.id_inst, 32'h0);

    // Randomized traffic; branches are never placed on a delay slot.
    verbose = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        rst = 1'b0;
        tick;
        rst = 1'b1;
      end
      bus.id_ready      = ($urandom_range(0, 3) != 0);
      bus.flush         = ($urandom_range(0, 24) == 0);
      bus.new_pc        = $urandom & 32'hFFFF_FFFC;
      bus.branch_flag   = !arch_pending && ($urandom_range(0, 5) == 0);
      bus.branch_target = $urandom & 32'hFFFF_FFFC;
      tick;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the OpenMIPS32 pipeline, directly upstream of the instruction ROM and feeding the decode (ID) stage. It owns the PC, drives the ROM chip-enable and address, and captures the returned instruction into a 2-entry fetch FIFO. The FIFO head is presented to ID with a valid/ready handshake. It applies branch redirects, keeping the MIPS delay slot, and exception flushes.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded at reset.
- clk  in  1: clock; all state changes on the rising edge.
- rst  in  1: asynchronous, active-low reset (asserted at 0).
- rom_ce  out  1: ROM chip enable; registered.
- rom_addr  out  32: fetch address; equals the PC register at all times.
- rom_inst  in  32: ROM data, combinational from rom_addr in the same cycle.
- id_valid  out  1: FIFO head is valid.
- id_pc  out  32: PC of the FIFO head; 0 when empty.
- id_inst  out  32: instruction of the FIFO head; 0 when empty.
- id_ready  in  1: ID accepts the head this cycle. Pop happens when id_valid && id_ready.
- branch_flag  in  1: taken branch/jump, qualified by a pop; the popped head is the branch.
- branch_target  in  32: redirect address for branch_flag.
- flush  in  1: exception/eret flush; unconditional.
- new_pc  in  32: redirect address for flush.

## Operation
- State:
  - pc (32b)
  - ce_q (1b)
  - FIFO of 2 entries {pc, inst}, with a head pointer and count 0..2
- rom_ce = ce_q. ce_q is 0 in reset and becomes 1 on the first clock edge after release, then stays 1.
- Fetch accepted in a cycle when all hold: ce_q=1, count<2, flush=0.
  - On accept: push {pc, rom_inst} and set pc <= pc+4 (modulo 2^32; 0xFFFF_FFFC wraps to 0).
  - If no fetch is accepted and there is no redirect, pc holds.
- Pop when id_valid && id_ready. Push and pop in the same cycle leaves count unchanged.
- Branch (branch_flag=1 with a pop, flush=0):
  - The delay slot is the instruction at popped_pc+4. It is kept: it is either FIFO entry 1 (count was 2) or this cycle's fetch (count was 1).
  - pc <= branch_target; the pc+4 update is overridden.
  - No entry younger than the delay slot exists, so nothing else is discarded.
- branch_flag without a pop is ignored.
- Flush (flush=1):
  - count <= 0; no push and no pop take effect.
  - pc <= new_pc.
  - branch_flag is ignored in the same cycle.
- Priority: reset > flush > branch > sequential.
- Output drive: id_valid = (count != 0). id_pc and id_inst come from the head entry, or 0 when empty.

## Timing
- Reset values: pc=RESET_PC, ce_q=0, count=0, head=0. Outputs: rom_ce=0, rom_addr=RESET_PC, id_valid=0, id_pc=0, id_inst=0.
- Reset may assert at any time. It clears the state immediately (asynchronously), including mid-branch or with a full FIFO.
- Start-up after reset release:
  - Edge 1: rom_ce goes to 1.
  - Edge 2: instruction at RESET_PC captured; id_valid=1 and pc=RESET_PC+4.
- Fetch-to-ID latency: 1 cycle. The instruction addressed in cycle N is visible at id_* in cycle N+1 if the FIFO was empty.
- Throughput: one instruction per cycle while id_ready=1 (count steady at 1).
- id_ready=0 for 2+ cycles: count reaches 2 and the PC freezes. No instruction is lost or duplicated.
- Redirect latency:
  - Target address is on rom_addr the cycle after branch_flag or flush.
  - After a flush, id_valid is 0 for that next cycle. The target instruction appears at id_* one cycle later.
- id_* are registered/FIFO-sourced. The only combinational input-to-state paths are id_ready, branch_flag and flush into the pc and count next-state logic. There is no combinational path from id_ready to id_*.

## Test plan
- Reset, release, and id_ready held at 1, with ROM word k = k:
  - id_valid rises 2 edges after release.
  - id_pc sequence is 0, 4, 8, … and id_inst sequence is 0, 1, 2, …, one per cycle.
- Back-pressure: after 0x0 and 0x4 are fetched, hold id_ready=0 for 5 cycles.
  - count=2, rom_addr holds 0x8, id_pc holds 0x0.
  - On release, id_pc goes 0x4 then 0x8 with no gap or duplicate.
- Branch with count=1: pop head 0x10 with branch_flag=1 and branch_target=0x100.
  - Next pops are 0x14 (delay slot) then 0x100; 0x18 never appears.
- Branch with count=2: head 0x10, entry 0x14, branch_target=0x200.
  - Pops are 0x14 then 0x200.
- Flush with branch_flag=1 and a full FIFO, new_pc=0x380:
  - Next cycle: count=0, id_valid=0, rom_addr=0x380.
  - The cycle after: id_pc=0x380. branch_target is never fetched.
- Wrap and mid-run reset:
  - Flush to 0xFFFF_FFFC: id_pc goes 0xFFFF_FFFC then 0x0.
  - Assert rst mid-stream: outputs return to their reset values immediately, and the start-up sequence from RESET_PC repeats after release.
